// File: rtl/exec_issue_queue.sv
// -----------------------------------------------------------------------------
// exec_issue_queue
//   In-order issue queue between decode and exec_sequencer. Micro-ops wait in a
//   small circular buffer. The head issues only when none of its source
//   registers has a pending write in the register scoreboard. A blocked head
//   holds back every younger entry, so issue stays strictly in order.
//
// Ports
//   clock      : single clock; all state changes on the rising edge
//   reset      : synchronous, active-low reset
//   flush      : synchronous flush; suppresses push/pop, empties the queue
//   in_valid   : decode presents a micro-op
//   in_ready   : queue accepts it (!full && !flush)
//   in_uop     : micro-op payload
//   in_rs1/2   : source register indices of in_uop
//   reg_busy   : one pending-write bit per architectural register
//   out_valid  : head is issuable (!empty && !hazard && !flush)
//   out_ready  : exec_sequencer accepts the head
//   out_uop    : head payload (meaningful only while out_valid=1)
//   count      : occupancy, 0..DEPTH
//   full/empty : count==DEPTH / count==0
// -----------------------------------------------------------------------------
module exec_issue_queue #(
  parameter int UOP_WIDTH      = 64,
  parameter int DEPTH          = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [UOP_WIDTH-1:0]         in_uop,
  input  logic [REG_ADDR_WIDTH-1:0]    in_rs1,
  input  logic [REG_ADDR_WIDTH-1:0]    in_rs2,
  input  logic [2**REG_ADDR_WIDTH-1:0] reg_busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [UOP_WIDTH-1:0]         out_uop,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Entry storage
  logic [UOP_WIDTH-1:0]      uop_q [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] rs1_q [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] rs2_q [DEPTH];

  // Control state
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic                      push, pop, hazard;
  logic [REG_ADDR_WIDTH-1:0] head_rs1, head_rs2;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // A pop in the same cycle never frees a slot for a push into a full queue,
  // so in_ready does not look at out_ready.
  assign in_ready = !full && !flush;
  assign push     = in_valid && in_ready;

  // Register 0 is hard-wired, so its busy bit never blocks issue.
  assign head_rs1 = rs1_q[rd_ptr_q];
  assign head_rs2 = rs2_q[rd_ptr_q];
  assign hazard   = ((head_rs1 != '0) && reg_busy[head_rs1]) ||
                    ((head_rs2 != '0) && reg_busy[head_rs2]);

  // Head content is only trusted when the queue is non-empty; empty masks any
  // stale entry sitting at the read pointer.
  assign out_valid = !empty && !hazard && !flush;
  assign pop       = out_valid && out_ready;
  assign out_uop   = uop_q[rd_ptr_q];

  // Next-state for pointers and occupancy. Pointers wrap for free because
  // DEPTH is a power of two.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: entry storage carries no reset; the pointers and count decide which
  // entries are live, so resetting the array would only add reset fan-out.
  // A push in a reset cycle lands in a slot that reset has just declared dead.
  always_ff @(posedge clock) begin
    if (push) begin
      uop_q[wr_ptr_q] <= in_uop;
      rs1_q[wr_ptr_q] <= in_rs1;
      rs2_q[wr_ptr_q] <= in_rs2;
    end
  end

endmodule

// File: tb/tb_exec_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_exec_issue_queue
//   Directed bench for exec_issue_queue with default parameters. Each accepted
//   push is queued in a scoreboard together with its source registers. Each
//   handshake pops the oldest scoreboard entry and compares it with out_uop.
//   The scoreboard also predicts occupancy, readiness and hazard blocking.
// -----------------------------------------------------------------------------
module tb_exec_issue_queue;

  localparam int UOP_WIDTH      = 64;
  localparam int DEPTH          = 4;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int CNT_W          = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [UOP_WIDTH-1:0]      uop;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
  } entry_t;

  logic                         clock = 1'b0;
  logic                         reset;
  logic                         flush;
  logic                         in_valid;
  logic                         in_ready;
  logic [UOP_WIDTH-1:0]         in_uop;
  logic [REG_ADDR_WIDTH-1:0]    in_rs1;
  logic [REG_ADDR_WIDTH-1:0]    in_rs2;
  logic [2**REG_ADDR_WIDTH-1:0] reg_busy;
  logic                         out_valid;
  logic                         out_ready;
  logic [UOP_WIDTH-1:0]         out_uop;
  logic [CNT_W-1:0]             count;
  logic                         full;
  logic                         empty;

  entry_t sb[$];
  int     n_asserts = 0;
  int     n_fail    = 0;

  exec_issue_queue #(
    .UOP_WIDTH      (UOP_WIDTH),
    .DEPTH          (DEPTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_uop    (in_uop),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .reg_busy  (reg_busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_uop   (out_uop),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [UOP_WIDTH-1:0] obs,
                       input logic [UOP_WIDTH-1:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_hazard();
    if (sb.size() == 0) return 1'b0;
    return ((sb[0].rs1 != '0) && reg_busy[sb[0].rs1]) ||
           ((sb[0].rs2 != '0) && reg_busy[sb[0].rs2]);
  endfunction

  // One clock cycle: inputs are already driven (just after the previous edge).
  // Combinational outputs are checked mid-cycle, the handshakes are applied
  // to the scoreboard, and the registered state is checked after the edge.
  task automatic cycle(input string tag);
    logic   exp_in_ready, exp_out_valid;
    entry_t head;
    #2;
    exp_in_ready  = (sb.size() != DEPTH) && !flush;
    exp_out_valid = (sb.size() != 0) && !model_hazard() && !flush;
    check({tag, ".in_ready"},  in_ready,  exp_in_ready);
    check({tag, ".out_valid"}, out_valid, exp_out_valid);
    if (!reset) begin
      sb.delete();
    end else if (flush) begin
      sb.delete();
    end else begin
      if (exp_out_valid && out_ready) begin
        head = sb.pop_front();
        check({tag, ".out_uop"}, out_uop, head.uop);
      end
      if (in_valid && exp_in_ready)
        sb.push_back('{uop: in_uop, rs1: in_rs1, rs2: in_rs2});
    end
    @(posedge clock);
    #1;
    check({tag, ".count"}, count, UOP_WIDTH'(sb.size()));
    check({tag, ".full"},  full,  sb.size() == DEPTH);
    check({tag, ".empty"}, empty, sb.size() == 0);
  endtask

  task automatic drive(input string tag, input logic iv,
                       input logic [UOP_WIDTH-1:0] uop,
                       input logic [REG_ADDR_WIDTH-1:0] rs1,
                       input logic [REG_ADDR_WIDTH-1:0] rs2,
                       input logic ordy, input logic fl, input logic rst);
    in_valid  = iv;
    in_uop    = uop;
    in_rs1    = rs1;
    in_rs2    = rs2;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    cycle(tag);
  endtask

  function automatic logic [UOP_WIDTH-1:0] mk_uop(input int tagv);
    return {32'(tagv), $urandom()};
  endfunction

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_uop    = '0;
    in_rs1    = '0;
    in_rs2    = '0;
    reg_busy  = '0;
    out_ready = 1'b0;
    @(posedge clock);
    #1;

    // Reset with traffic offered: nothing may be accepted.
    drive("rst0", 1'b1, mk_uop(32'hEE), 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    drive("rst1", 1'b0, '0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);

    // Fill: A..D back to back with out_ready=0, then a refused 5th.
    for (int i = 0; i < DEPTH; i++)
      drive("fill", 1'b1, mk_uop(32'hA + i), 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    check("fill.count4", count, UOP_WIDTH'(4));
    drive("fill5", 1'b1, mk_uop(32'hE), 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);

    // Drain in order.
    for (int i = 0; i < DEPTH; i++)
      drive("drain", 1'b0, '0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);

    // Latency and wrap: push with out_ready=1 every cycle; each uop issues one
    // cycle after its push, never in the push cycle itself.
    for (int i = 0; i < 6; i++)
      drive("stream", 1'b1, mk_uop(32'h100 + i), 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
    drive("stream.end", 1'b0, '0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);

    // Simultaneous push and pop at count 2, then pop-only when full.
    drive("sim.p0", 1'b1, mk_uop(32'h200), 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    drive("sim.p1", 1'b1, mk_uop(32'h201), 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    drive("sim.pp", 1'b1, mk_uop(32'h202), 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
    check("sim.count2", count, UOP_WIDTH'(2));
    drive("sim.p3", 1'b1, mk_uop(32'h203), 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    drive("sim.p4", 1'b1, mk_uop(32'h204), 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    drive("sim.fullpp", 1'b1, mk_uop(32'h205), 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
    check("sim.count3", count, UOP_WIDTH'(3));
    for (int i = 0; i < 3; i++)
      drive("sim.drain", 1'b0, '0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);

    // Hazard on rs1=5 blocks the head and the younger entry behind it.
    drive("haz.push", 1'b1, mk_uop(32'h300), 5'd5, 5'd0, 1'b0, 1'b0, 1'b1);
    drive("haz.push2", 1'b1, mk_uop(32'h301), 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    reg_busy[5] = 1'b1;
    drive("haz.blk0", 1'b0, '0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
    drive("haz.blk1", 1'b0, '0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
    check("haz.count", count, UOP_WIDTH'(2));
    // Clearing the busy bit mid-cycle must raise out_valid in that same cycle.
    in_valid = 1'b0;
    #2;
    check("haz.blocked", out_valid, 1'b0);
    reg_busy[5] = 1'b0;
    #1;
    check("haz.release", out_valid, 1'b1);
    #1;
    cycle("haz.pop");
    drive("haz.pop2", 1'b0, '0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);

    // Hazard on rs2, and register 0 never blocks.
    reg_busy[0] = 1'b1;
    reg_busy[7] = 1'b1;
    drive("haz.r2push", 1'b1, mk_uop(32'h310), 5'd0, 5'd7, 1'b0, 1'b0, 1'b1);
    drive("haz.r2blk", 1'b0, '0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
    reg_busy[7] = 1'b0;
    drive("haz.r2pop", 1'b0, '0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
    drive("haz.r0push", 1'b1, mk_uop(32'h320), 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    drive("haz.r0pop", 1'b0, '0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
    reg_busy = '0;

    // Flush at count 3 with traffic offered on both sides.
    for (int i = 0; i < 3; i++)
      drive("fl.fill", 1'b1, mk_uop(32'h400 + i), 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    drive("fl.flush", 1'b1, mk_uop(32'h4FF), 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
    check("fl.count0", count, UOP_WIDTH'(0));

    // Same with reset instead of flush.
    for (int i = 0; i < 3; i++)
      drive("rs.fill", 1'b1, mk_uop(32'h500 + i), 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    drive("rs.reset", 1'b1, mk_uop(32'h5FF), 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    check("rs.empty", empty, 1'b1);

    // The queue works normally after the flush and the reset.
    drive("post.push", 1'b1, mk_uop(32'h600), 5'd3, 5'd4, 1'b0, 1'b0, 1'b1);
    drive("post.pop", 1'b0, '0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);

    check("sb.drained", UOP_WIDTH'(sb.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
